// File: rtl/rf_pkg.sv
// Shared RegFile write-port types and widths for the write-back arbiter.
package rf_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] adrs;
    logic [REG_DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small in-order buffer for mult/div results awaiting a free RegFile write cycle.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              push_i,
  input  logic [REG_AW-1:0] push_adrs_i,
  input  logic [REG_DW-1:0] push_data_i,
  input  logic              pop_i,
  output logic [REG_AW-1:0] head_adrs_o,
  output logic [REG_DW-1:0] head_data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [31:0]       pending_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [REG_AW-1:0] adrs_q [Depth];
  logic [REG_DW-1:0] data_q [Depth];
  logic [Depth-1:0]  valid_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign head_adrs_o = adrs_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      // Depth is a power of two, so the natural pointer overflow is the wrap.
      if (push_ok) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      adrs_q[wr_ptr_q] <= push_adrs_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < Depth; i++) begin
      if (valid_q[i]) pending_o[adrs_q[i]] = 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the RegFile write port: WB stage has priority, mult/div results drain on idle cycles.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned Depth   = 2,
  parameter int unsigned MaxWait = 4
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_adrs_i,
  input  logic [REG_DW-1:0] wb_data_i,
  input  logic              md_valid_i,
  input  logic [REG_AW-1:0] md_adrs_i,
  input  logic [REG_DW-1:0] md_data_i,
  output logic              md_ready_o,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_w_adrs_o,
  output logic [REG_DW-1:0] rf_w_data_o,
  output logic [31:0]       pending_o,
  output logic              starve_req_o,
  output logic              order_err_o
);

  localparam int unsigned WaitW = $clog2(MaxWait + 1);

  logic              a_valid, fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [REG_AW-1:0] head_adrs;
  logic [REG_DW-1:0] head_data;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              order_err_q, order_err_d;
  wb_req_t           rf_req;

  assign a_valid    = wb_we_i && (wb_adrs_i != REG_ZERO);
  assign md_ready_o = !fifo_full;
  // Writes to $0 are acknowledged but never stored.
  assign fifo_push  = md_valid_i && md_ready_o && (md_adrs_i != REG_ZERO);
  assign fifo_pop   = !a_valid && !fifo_empty;

  rf_wb_fifo #(
    .Depth(Depth)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .push_i      (fifo_push),
    .push_adrs_i (md_adrs_i),
    .push_data_i (md_data_i),
    .pop_i       (fifo_pop),
    .head_adrs_o (head_adrs),
    .head_data_o (head_data),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .pending_o   (pending_o)
  );

  always_comb begin
    rf_req = '0;
    if (a_valid) begin
      rf_req = '{we: 1'b1, adrs: wb_adrs_i, data: wb_data_i};
    end else if (!fifo_empty) begin
      rf_req = '{we: 1'b1, adrs: head_adrs, data: head_data};
    end
  end

  assign rf_we_o     = rf_req.we;
  assign rf_w_adrs_o = rf_req.adrs;
  assign rf_w_data_o = rf_req.data;

  always_comb begin
    wait_d = wait_q;
    if (fifo_empty || fifo_pop) begin
      wait_d = '0;
    end else if (wait_q != WaitW'(MaxWait)) begin
      wait_d = wait_q + WaitW'(1);
    end
    order_err_d = order_err_q || (a_valid && pending_o[wb_adrs_i]);
  end

  assign starve_req_o = (wait_q == WaitW'(MaxWait)) && !fifo_empty;
  assign order_err_o  = order_err_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wait_q      <= '0;
      order_err_q <= 1'b0;
    end else begin
      wait_q      <= wait_d;
      order_err_q <= order_err_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scenarios for the write-back arbiter with hand-computed expectations.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we, md_valid;
  logic [4:0]  wb_adrs, md_adrs;
  logic [31:0] wb_data, md_data;
  logic        md_ready, rf_we, starve_req, order_err;
  logic [4:0]  rf_w_adrs;
  logic [31:0] rf_w_data, pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(
    .Depth   (2),
    .MaxWait (4)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (rst_n),
    .wb_we_i      (wb_we),
    .wb_adrs_i    (wb_adrs),
    .wb_data_i    (wb_data),
    .md_valid_i   (md_valid),
    .md_adrs_i    (md_adrs),
    .md_data_i    (md_data),
    .md_ready_o   (md_ready),
    .rf_we_o      (rf_we),
    .rf_w_adrs_o  (rf_w_adrs),
    .rf_w_data_o  (rf_w_data),
    .pending_o    (pending),
    .starve_req_o (starve_req),
    .order_err_o  (order_err)
  );

  // Advance past the next edge; caller then drives inputs and checks after #1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wb_we = we; wb_adrs = wa; wb_data = wd;
    md_valid = mv; md_adrs = ma; md_data = md;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      n_checks++;
      if (md_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", md_ready); end
      n_checks++;
      if (pending !== 32'h0) begin n_fail++; $display("FAIL rst_pending: got %h want 0", pending); end
      n_checks++;
      if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", rf_we); end
      n_checks++;
      if (starve_req !== 1'b0 || order_err !== 1'b0) begin
        n_fail++; $display("FAIL rst_flags: got starve=%b err=%b want 0 0", starve_req, order_err);
      end
    end
    tick();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    n_checks++;
    if (rf_we !== 1'b0 || pending !== 32'h0) begin
      n_fail++; $display("FAIL rst_count0: got we=%b pend=%h want 0 0", rf_we, pending);
    end
  endtask

  task automatic test_idle_drain();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hAAAA0001);
    n_checks++;
    if (rf_we !== 1'b0 || pending !== 32'h0) begin
      n_fail++; $display("FAIL drain_pre: got we=%b pend=%h want 0 0", rf_we, pending);
    end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    n_checks++;
    if (rf_we !== 1'b1 || rf_w_adrs !== 5'd5 || rf_w_data !== 32'hAAAA0001) begin
      n_fail++; $display("FAIL drain_write: got %b/%0d/%h want 1/5/aaaa0001", rf_we, rf_w_adrs, rf_w_data);
    end
    n_checks++;
    if (pending !== 32'h20) begin n_fail++; $display("FAIL drain_pend1: got %h want 20", pending); end
    tick();
    n_checks++;
    if (pending !== 32'h0 || rf_we !== 1'b0 || rf_w_adrs !== 5'd0 || rf_w_data !== 32'h0) begin
      n_fail++; $display("FAIL drain_after: got pend=%h we=%b a=%0d d=%h want 0", pending, rf_we, rf_w_adrs, rf_w_data);
    end
  endtask

  task automatic test_contention();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd6, 32'h6666);
    n_checks++;
    if (rf_w_adrs !== 5'd3 || rf_w_data !== 32'h33 || md_ready !== 1'b1) begin
      n_fail++; $display("FAIL cont_c0: got a=%0d d=%h rdy=%b want 3/33/1", rf_w_adrs, rf_w_data, md_ready);
    end
    tick();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h7777);
    n_checks++;
    if (md_ready !== 1'b1 || pending !== 32'h40 || starve_req !== 1'b0) begin
      n_fail++; $display("FAIL cont_c1: got rdy=%b pend=%h st=%b want 1/40/0", md_ready, pending, starve_req);
    end
    for (int c = 2; c <= 4; c++) begin
      tick();
      drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
      n_checks++;
      if (md_ready !== 1'b0 || starve_req !== 1'b0 || pending !== 32'hC0 || rf_w_adrs !== 5'd3) begin
        n_fail++; $display("FAIL cont_blocked%0d: got rdy=%b st=%b pend=%h a=%0d want 0/0/c0/3",
                           c, md_ready, starve_req, pending, rf_w_adrs);
      end
    end
    tick();
    n_checks++;
    if (starve_req !== 1'b1) begin n_fail++; $display("FAIL cont_starve: got %b want 1", starve_req); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    n_checks++;
    if (rf_we !== 1'b1 || rf_w_adrs !== 5'd6 || rf_w_data !== 32'h6666 || starve_req !== 1'b1) begin
      n_fail++; $display("FAIL cont_bubble6: got %b/%0d/%h st=%b want 1/6/6666 st=1", rf_we, rf_w_adrs, rf_w_data, starve_req);
    end
    tick();
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
    n_checks++;
    if (starve_req !== 1'b0 || pending !== 32'h80 || md_ready !== 1'b1 || rf_w_adrs !== 5'd3) begin
      n_fail++; $display("FAIL cont_after6: got st=%b pend=%h rdy=%b a=%0d want 0/80/1/3", starve_req, pending, md_ready, rf_w_adrs);
    end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    n_checks++;
    if (rf_we !== 1'b1 || rf_w_adrs !== 5'd7 || rf_w_data !== 32'h7777) begin
      n_fail++; $display("FAIL cont_bubble7: got %b/%0d/%h want 1/7/7777", rf_we, rf_w_adrs, rf_w_data);
    end
    tick();
    n_checks++;
    if (rf_we !== 1'b0 || pending !== 32'h0) begin
      n_fail++; $display("FAIL cont_empty: got we=%b pend=%h want 0 0", rf_we, pending);
    end
  endtask

  task automatic test_zero_reg();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9999);
    tick();
    drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    n_checks++;
    if (rf_we !== 1'b1 || rf_w_adrs !== 5'd9 || rf_w_data !== 32'h9999) begin
      n_fail++; $display("FAIL zero_wb: got %b/%0d/%h want 1/9/9999", rf_we, rf_w_adrs, rf_w_data);
    end
    n_checks++;
    if (md_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b want 1", md_ready); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    n_checks++;
    if (rf_we !== 1'b0 || pending !== 32'h0 || md_ready !== 1'b1) begin
      n_fail++; $display("FAIL zero_md: got we=%b pend=%h rdy=%b want 0/0/1", rf_we, pending, md_ready);
    end
  endtask

  task automatic test_full_push_pop();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'hA);
    tick();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd11, 32'hB);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC);
    n_checks++;
    if (md_ready !== 1'b0 || pending !== 32'h0C00) begin
      n_fail++; $display("FAIL full_ready: got rdy=%b pend=%h want 0/c00", md_ready, pending);
    end
    n_checks++;
    if (rf_w_adrs !== 5'd10 || rf_w_data !== 32'hA) begin
      n_fail++; $display("FAIL full_pop10: got %0d/%h want 10/a", rf_w_adrs, rf_w_data);
    end
    tick();
    n_checks++;
    if (md_ready !== 1'b1 || pending !== 32'h0800 || rf_w_adrs !== 5'd11 || rf_w_data !== 32'hB) begin
      n_fail++; $display("FAIL full_pop11: got rdy=%b pend=%h %0d/%h want 1/800/11/b", md_ready, pending, rf_w_adrs, rf_w_data);
    end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    n_checks++;
    if (rf_we !== 1'b1 || rf_w_adrs !== 5'd12 || rf_w_data !== 32'hC || pending !== 32'h1000) begin
      n_fail++; $display("FAIL full_wrap12: got %b/%0d/%h pend=%h want 1/12/c/1000", rf_we, rf_w_adrs, rf_w_data, pending);
    end
    tick();
    n_checks++;
    if (rf_we !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b want 0", rf_we); end
  endtask

  task automatic test_violation_reset();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h4B);
    tick();
    drive(1'b1, 5'd4, 32'h4A, 1'b0, 5'd0, 32'h0);
    n_checks++;
    if (rf_w_adrs !== 5'd4 || rf_w_data !== 32'h4A || order_err !== 1'b0) begin
      n_fail++; $display("FAIL viol_a: got %0d/%h err=%b want 4/4a/0", rf_w_adrs, rf_w_data, order_err);
    end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    n_checks++;
    if (order_err !== 1'b1 || rf_we !== 1'b1 || rf_w_adrs !== 5'd4 || rf_w_data !== 32'h4B) begin
      n_fail++; $display("FAIL viol_b: got err=%b %b/%0d/%h want 1/1/4/4b", order_err, rf_we, rf_w_adrs, rf_w_data);
    end
    tick();
    n_checks++;
    if (order_err !== 1'b1 || rf_we !== 1'b0) begin
      n_fail++; $display("FAIL viol_sticky: got err=%b we=%b want 1 0", order_err, rf_we);
    end
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd8, 32'h8);
    tick();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd13, 32'hD);
    tick();
    rst_n = 1'b0;
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
    n_checks++;
    if (pending !== 32'h2100) begin n_fail++; $display("FAIL viol_prerst: got %h want 2100", pending); end
    tick();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    n_checks++;
    if (pending !== 32'h0 || rf_we !== 1'b0 || md_ready !== 1'b1) begin
      n_fail++; $display("FAIL viol_rst_fifo: got pend=%h we=%b rdy=%b want 0/0/1", pending, rf_we, md_ready);
    end
    n_checks++;
    if (order_err !== 1'b0 || starve_req !== 1'b0) begin
      n_fail++; $display("FAIL viol_rst_flags: got err=%b st=%b want 0 0", order_err, starve_req);
    end
  endtask

  initial begin
    test_reset();
    test_idle_drain();
    test_contention();
    test_zero_reg();
    test_full_push_pop();
    test_violation_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
